// File: rtl/evt_toggle_tx.sv
// Event-to-toggle transmitter: each accepted event pulse inverts `out`; the next
// inversion waits for the far domain to echo the level back on `ack_in`.
// Optional pending-event queue is compiled in with `define EVT_TOGGLE_TX_QUEUE_EN.
module evt_toggle_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out,
    input  logic             ack_in,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    input  logic             ovf_clr
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                 state_reg, state_next;
    logic                   out_reg, out_next;
    logic                   ovf_reg, ovf_next;
    logic                   drop;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   ack_s;
    logic                   done;

    // Plain shift synchronizer; ack_in is asynchronous to clk.
    assign sync_next = {sync_reg[SYNC_STAGES-2:0], ack_in};
    assign ack_s     = sync_reg[SYNC_STAGES-1];
    assign done      = (ack_s == out_reg);

`ifdef EVT_TOGGLE_TX_QUEUE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] pending_reg, pending_next;
`endif

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        drop       = 1'b0;
`ifdef EVT_TOGGLE_TX_QUEUE_EN
        pending_next = pending_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in) begin
                    out_next   = ~out_reg;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
`ifdef EVT_TOGGLE_TX_QUEUE_EN
                if (!done) begin
                    if (in) begin
                        if (pending_reg != CNT_MAX)
                            pending_next = pending_reg + CNT_ONE;
                        else
                            drop = 1'b1;
                    end
                end else if (pending_reg != '0 || in) begin
                    // A new event on the done edge replaces the dequeued one.
                    out_next = ~out_reg;
                    if (pending_reg != '0 && !in)
                        pending_next = pending_reg - CNT_ONE;
                end else begin
                    state_next = IDLE;
                end
`else
                drop = in;
                if (done)
                    state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
        // Set beats clear when both land in the same cycle.
        ovf_next = drop | (ovf_reg & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            out_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            sync_reg  <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            ovf_reg   <= ovf_next;
            sync_reg  <= sync_next;
        end
    end

`ifdef EVT_TOGGLE_TX_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset)
            pending_reg <= '0;
        else
            pending_reg <= pending_next;
    end
    assign pending = pending_reg;
`else
    assign pending = '0;
`endif

    assign out  = out_reg;
    assign busy = (state_reg == WAIT_ACK);
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_evt_toggle_tx.sv
// Self-checking bench for evt_toggle_tx: echo delay line models the far domain,
// a scoreboard of expected out inversions is checked by a negedge monitor.
module tb_evt_toggle_tx;
    localparam int SS = 2;
    localparam int CW = 4;
`ifdef EVT_TOGGLE_TX_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          ack_in;
    logic          out, busy, ovf;
    logic [CW-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] dl = '0;
    int          ack_dly = 3;
    logic        hold_en = 1'b0;
    logic        hold_val = 1'b0;

    typedef struct {
        logic level;
        int   gap;
    } exp_t;
    exp_t sb[$];
    logic prev_out = 1'b0;
    int   last_cyc = 0;

    evt_toggle_tx #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in(in), .out(out), .ack_in(ack_in),
        .busy(busy), .pending(pending), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Far-domain model: echo of out delayed ack_dly cycles, reset with the DUT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) dl <= '0;
        else       dl <= {dl[30:0], out};
    end
    assign ack_in = hold_en ? hold_val : dl[ack_dly-1];

    // Scoreboard monitor: every inversion outside reset must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_out = out;
        end else if (out !== prev_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_toggle out=%0b cycle=%0d required no toggle", out, cyc);
            end else begin
                e = sb.pop_front();
                if (out !== e.level) begin
                    errors++;
                    $display("FAIL toggle_level got %0b expected %0b cycle=%0d", out, e.level, cyc);
                end
                if (e.gap > 0) begin
                    checks++;
                    if (cyc - last_cyc != e.gap) begin
                        errors++;
                        $display("FAIL toggle_gap got %0d expected %0d cycle=%0d", cyc - last_cyc, e.gap, cyc);
                    end
                end
            end
            $display("toggle out=%0b cycle=%0d pending=%0d", out, cyc, pending);
            last_cyc = cyc;
            prev_out = out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset   = 1'b1;
        hold_en = 1'b0;
        in      = 1'b0;
        ovf_clr = 1'b0;
        repeat (SS + 3) step();
        reset = 1'b0;
    endtask

    // Queue n expected inversions starting at first_level.
    task automatic push_toggles(input int n, input logic first_level, input int first_gap, input int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.level = first_level ^ logic'(i[0]);
            e.gap   = (i == 0) ? first_gap : gap;
            sb.push_back(e);
        end
    endtask

    task automatic pulses(input int n);
        in = 1'b1;
        repeat (n) step();
        in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (SS + 3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (out !== 1'b0)     begin errors++; $display("FAIL reset_out got %0b expected 0", out); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
        if (pending !== '0)   begin errors++; $display("FAIL reset_pending got %0d expected 0", pending); end
        if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %0b expected 0", ovf); end
        $display("reset out=%0b busy=%0b pending=%0d ovf=%0b", out, busy, pending, ovf);
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int bc = 0;
        int pmax = 0;
        do_reset();
        ack_dly = 3;
        push_toggles(1, 1'b1, 0, 0);
        pulses(1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (int'(pending) > pmax) pmax = int'(pending);
        end
        checks += 5;
        if (bc != 1 + 3 + SS) begin errors++; $display("FAIL single_busy_cycles got %0d expected %0d", bc, 1 + 3 + SS); end
        if (pmax != 0)        begin errors++; $display("FAIL single_pending got %0d expected 0", pmax); end
        if (out !== 1'b1)     begin errors++; $display("FAIL single_out got %0b expected 1", out); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL single_busy_end got %0b expected 0", busy); end
        if (sb.size() != 0)   begin errors++; $display("FAIL single_missing_toggles got %0d left expected 0", sb.size()); end
        $display("single busy_cycles=%0d out=%0b", bc, out);
    endtask

    task automatic test_burst();
        int pmax = 0;
        do_reset();
        ack_dly = 10;
        push_toggles(QEN ? 5 : 1, 1'b1, 0, 10 + SS + 1);
        pulses(5);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (int'(pending) > pmax) pmax = int'(pending);
        end
        checks += 6;
        if (pmax != (QEN ? 4 : 0)) begin errors++; $display("FAIL burst_peak got %0d expected %0d", pmax, QEN ? 4 : 0); end
        if (out !== 1'b1)          begin errors++; $display("FAIL burst_out got %0b expected 1", out); end
        if (pending !== '0)        begin errors++; $display("FAIL burst_pending got %0d expected 0", pending); end
        if (ovf !== !QEN)          begin errors++; $display("FAIL burst_ovf got %0b expected %0b", ovf, !QEN); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL burst_busy got %0b expected 0", busy); end
        if (sb.size() != 0)        begin errors++; $display("FAIL burst_missing_toggles got %0d left expected 0", sb.size()); end
        $display("burst peak=%0d out=%0b ovf=%0b", pmax, out, ovf);
    endtask

    task automatic test_saturation();
        do_reset();
        ack_dly  = 1;
        hold_en  = 1'b1;
        hold_val = 1'b0;
        push_toggles(1, 1'b1, 0, 0);
        pulses(20);
        @(negedge clk);
        checks += 4;
        if (pending !== (QEN ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_pending got %0d expected %0d", pending, QEN ? 15 : 0); end
        if (ovf !== 1'b1)  begin errors++; $display("FAIL sat_ovf got %0b expected 1", ovf); end
        if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %0b expected 1", busy); end
        if (out !== 1'b1)  begin errors++; $display("FAIL sat_out got %0b expected 1", out); end
        $display("saturation pending=%0d ovf=%0b", pending, ovf);
        // Drop and clear in the same cycle: the set must win.
        step();
        in = 1'b1;
        ovf_clr = 1'b1;
        step();
        in = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b expected 1", ovf); end
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b expected 0", ovf); end
        $display("ovf_clr ovf=%0b", ovf);
        push_toggles(QEN ? 15 : 0, 1'b0, 0, SS + 2);
        step();
        hold_en = 1'b0;
        repeat (100) @(negedge clk);
        checks += 4;
        if (sb.size() != 0)         begin errors++; $display("FAIL sat_missing_toggles got %0d left expected 0", sb.size()); end
        if (out !== (QEN ? 1'b0 : 1'b1)) begin errors++; $display("FAIL sat_final_out got %0b expected %0b", out, !QEN); end
        if (pending !== '0)         begin errors++; $display("FAIL sat_final_pending got %0d expected 0", pending); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL sat_final_busy got %0b expected 0", busy); end
        $display("saturation drained out=%0b", out);
    endtask

    task automatic test_done_edge();
        do_reset();
        ack_dly = 1;
        push_toggles(QEN ? 2 : 1, 1'b1, 0, SS + 2);
        pulses(1);
        repeat (SS + 1) step();
        pulses(1);
        @(negedge clk);
        checks += 3;
        if (pending !== '0) begin errors++; $display("FAIL done_edge_pending got %0d expected 0", pending); end
        if (busy !== QEN)   begin errors++; $display("FAIL done_edge_busy got %0b expected %0b", busy, QEN); end
        if (ovf !== !QEN)   begin errors++; $display("FAIL done_edge_ovf got %0b expected %0b", ovf, !QEN); end
        repeat (30) @(negedge clk);
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL done_edge_missing got %0d left expected 0", sb.size()); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL done_edge_idle got %0b expected 0", busy); end
        $display("done_edge out=%0b ovf=%0b", out, ovf);
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_dly = 10;
        push_toggles(1, 1'b1, 0, 0);
        pulses(4);
        @(negedge clk);
        checks += 2;
        if (pending !== (QEN ? 4'd3 : 4'd0)) begin errors++; $display("FAIL mid_pending_pre got %0d expected %0d", pending, QEN ? 3 : 0); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %0b expected 1", busy); end
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        checks += 4;
        if (out !== 1'b0)   begin errors++; $display("FAIL mid_out got %0b expected 0", out); end
        if (pending !== '0) begin errors++; $display("FAIL mid_pending got %0d expected 0", pending); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got %0b expected 0", busy); end
        if (ovf !== 1'b0)   begin errors++; $display("FAIL mid_ovf got %0b expected 0", ovf); end
        $display("reset_mid out=%0b pending=%0d busy=%0b", out, pending, busy);
        repeat (SS + 2) step();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL mid_missing got %0d left expected 0", sb.size()); end
        if (out !== 1'b0)   begin errors++; $display("FAIL mid_quiet_out got %0b expected 0", out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_done_edge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
